// File: rtl/seq_engine.sv
// seq_engine: Fibonacci / Collatz / mm.ss stopwatch generator, one step per En strobe.
// Latency: Out/Valid/Done/Ovf/Steps are registered and update 1 cycle after Load or En.
// Backpressure: none. En is ignored outside RUN, and Load always wins over En.
// Ports: Clk, Rst_n (async, active-low); Mode/Load/Load_val start or restart a sequence;
//        En steps it; Out is the current value, Valid means a sequence is loaded, Done is
//        the terminal flag (a wrap pulse in stopwatch mode), Ovf flags overflow, Steps
//        counts steps and saturates.
// Optional: define SEQ_STEP_LIMIT_EN to halt Fibonacci/Collatz after STEP_LIMIT steps.
module seq_engine #(
  parameter int WIDTH        = 16,
  parameter int STEP_WIDTH   = 8,
  parameter int FIB_SEED_0   = 0,
  parameter int FIB_SEED_1   = 1,
  parameter int COLLATZ_SEED = 27,
  parameter int SW_MAX       = 9959,
  parameter int STEP_LIMIT   = 200
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [1:0]            Mode,
  input  logic                  Load,
  input  logic [WIDTH-1:0]      Load_val,
  input  logic                  En,
  output logic [WIDTH-1:0]      Out,
  output logic                  Valid,
  output logic                  Done,
  output logic                  Ovf,
  output logic [STEP_WIDTH-1:0] Steps
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [1:0] MODE_FIB  = 2'b00;
  localparam logic [1:0] MODE_COL  = 2'b01;
  localparam logic [1:0] MODE_SW   = 2'b10;
  localparam logic [1:0] MODE_NONE = 2'b11;

  localparam logic [WIDTH-1:0] HUNDRED  = WIDTH'(100);
  localparam logic [WIDTH-1:0] SS_LAST  = WIDTH'(59);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] SW_MAX_W = WIDTH'(SW_MAX);
  localparam logic [WIDTH-1:0] FIB0_W   = WIDTH'(FIB_SEED_0);
  localparam logic [WIDTH-1:0] FIB1_W   = WIDTH'(FIB_SEED_1);
  localparam logic [WIDTH-1:0] COL_W    = WIDTH'(COLLATZ_SEED);

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [WIDTH-1:0]       prev_q, prev_d, out_d;
  logic                   valid_d, done_d, ovf_d;
  logic [STEP_WIDTH-1:0]  steps_d, steps_inc;

  logic [WIDTH:0]         fib_sum;
  logic [WIDTH+1:0]       col_odd, col_next;
  logic [WIDTH-1:0]       sw_sec, sw_roll, load_ss;

  // Fibonacci sum carries one extra bit; the carry is the overflow flag.
  assign fib_sum   = {1'b0, Out} + {1'b0, prev_q};
  // 3x+1 built as x + 2x + 1 in WIDTH+2 bits so nothing is lost before the range check.
  assign col_odd   = {2'b00, Out} + {1'b0, Out, 1'b0} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign col_next  = Out[0] ? col_odd : {3'b000, Out[WIDTH-1:1]};
  assign sw_sec    = Out % HUNDRED;
  assign sw_roll   = (Out / HUNDRED + ONE_W) * HUNDRED;
  assign load_ss   = Load_val % HUNDRED;
  assign steps_inc = (&Steps) ? Steps : Steps + 1'b1;

`ifdef SEQ_STEP_LIMIT_EN
  logic lim_hit;
  assign lim_hit = (int'(steps_inc) == STEP_LIMIT);
`else
  localparam int UNUSED_STEP_LIMIT = STEP_LIMIT;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    out_d   = Out;
    prev_d  = prev_q;
    valid_d = Valid;
    done_d  = Done;
    ovf_d   = Ovf;
    steps_d = Steps;

    if (Load) begin
      mode_d  = Mode;
      steps_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      valid_d = 1'b1;
      prev_d  = '0;
      state_d = RUN;
      case (Mode)
        MODE_FIB: begin
          out_d  = FIB1_W;
          prev_d = FIB0_W;
        end
        MODE_COL: begin
          out_d = (Load_val == '0) ? COL_W : Load_val;
          // A sequence that starts at 1 is already terminated.
          if (out_d == ONE_W) begin
            state_d = HALT;
            done_d  = 1'b1;
          end
        end
        MODE_SW: begin
          out_d = (load_ss <= SS_LAST && Load_val <= SW_MAX_W) ? Load_val : '0;
        end
        default: begin
          out_d   = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end else begin
      // In stopwatch mode Done is a single-cycle wrap pulse, not a level.
      if (mode_q == MODE_SW) done_d = 1'b0;

      if (En && state_q == RUN) begin
        case (mode_q)
          MODE_FIB: begin
            if (fib_sum[WIDTH]) begin
              ovf_d   = 1'b1;
              done_d  = 1'b1;
              state_d = HALT;
            end else begin
              out_d   = fib_sum[WIDTH-1:0];
              prev_d  = Out;
              steps_d = steps_inc;
`ifdef SEQ_STEP_LIMIT_EN
              if (lim_hit) begin
                state_d = HALT;
                done_d  = 1'b1;
              end
`endif
            end
          end
          MODE_COL: begin
            if (col_next[WIDTH+1:WIDTH] != 2'b00) begin
              ovf_d   = 1'b1;
              done_d  = 1'b1;
              state_d = HALT;
            end else begin
              out_d   = col_next[WIDTH-1:0];
              steps_d = steps_inc;
              if (col_next[WIDTH-1:0] == ONE_W) begin
                state_d = HALT;
                done_d  = 1'b1;
              end
`ifdef SEQ_STEP_LIMIT_EN
              if (lim_hit) begin
                state_d = HALT;
                done_d  = 1'b1;
              end
`endif
            end
          end
          MODE_SW: begin
            steps_d = steps_inc;
            // Terminal check first: 99:59 wraps to 0, never to 100:00.
            if (Out >= SW_MAX_W) begin
              out_d  = '0;
              done_d = 1'b1;
            end else if (sw_sec == SS_LAST) begin
              out_d = sw_roll;
            end else begin
              out_d = Out + ONE_W;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_NONE;
      Out     <= '0;
      prev_q  <= '0;
      Valid   <= 1'b0;
      Done    <= 1'b0;
      Ovf     <= 1'b0;
      Steps   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      Out     <= out_d;
      prev_q  <= prev_d;
      Valid   <= valid_d;
      Done    <= done_d;
      Ovf     <= ovf_d;
      Steps   <= steps_d;
    end
  end

endmodule

// File: tb/tb_seq_engine.sv
module tb_seq_engine;
  localparam int W   = 16;
  localparam int SWD = 8;
  localparam int LIM = 5;
  localparam int MAXV = (1 << W) - 1;
  localparam int SMAX = (1 << SWD) - 1;
`ifdef SEQ_STEP_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic [1:0]     Mode;
  logic           Load;
  logic [W-1:0]   Load_val;
  logic           En;
  logic [W-1:0]   Out;
  logic           Valid, Done, Ovf;
  logic [SWD-1:0] Steps;

  int checks = 0;
  int errors = 0;

  // reference model state (state: 0 idle, 1 running, 2 halted)
  int m_mode, m_st, m_out, m_prev, m_steps;
  bit m_valid, m_done, m_ovf;

  always #5 Clk = ~Clk;

  seq_engine #(
    .WIDTH(W), .STEP_WIDTH(SWD), .FIB_SEED_0(0), .FIB_SEED_1(1),
    .COLLATZ_SEED(27), .SW_MAX(9959), .STEP_LIMIT(LIM)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Mode(Mode), .Load(Load), .Load_val(Load_val),
    .En(En), .Out(Out), .Valid(Valid), .Done(Done), .Ovf(Ovf), .Steps(Steps)
  );

  // Apply one cycle of inputs, then leave the outputs ready to sample 1 ns after the edge.
  task automatic drive(input logic ld, input logic [1:0] md, input logic [W-1:0] val, input logic en);
    Load = ld; Mode = md; Load_val = val; En = en;
    @(posedge Clk); #1;
    Load = 1'b0; En = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 3; m_st = 0; m_out = 0; m_prev = 0; m_steps = 0;
    m_valid = 0; m_done = 0; m_ovf = 0;
  endtask

  task automatic model_apply(input bit ld, input int md, input int val, input bit en);
    int nx;
    bit stepped;
    stepped = 0;
    if (ld) begin
      m_mode = md; m_steps = 0; m_done = 0; m_ovf = 0; m_valid = 1; m_st = 1; m_prev = 0;
      case (md)
        0: begin m_out = 1; m_prev = 0; end
        1: begin
          m_out = (val == 0) ? 27 : val;
          if (m_out == 1) begin m_st = 2; m_done = 1; end
        end
        2: m_out = (val % 100 <= 59 && val <= 9959) ? val : 0;
        default: begin m_out = 0; m_valid = 0; m_st = 0; end
      endcase
    end else begin
      if (m_mode == 2) m_done = 0;
      if (en && m_st == 1) begin
        case (m_mode)
          0: begin
            nx = m_out + m_prev;
            if (nx > MAXV) begin m_ovf = 1; m_done = 1; m_st = 2; end
            else begin m_prev = m_out; m_out = nx; stepped = 1; end
          end
          1: begin
            nx = (m_out % 2 == 0) ? m_out / 2 : 3 * m_out + 1;
            if (nx > MAXV) begin m_ovf = 1; m_done = 1; m_st = 2; end
            else begin
              m_out = nx; stepped = 1;
              if (nx == 1) begin m_st = 2; m_done = 1; end
            end
          end
          2: begin
            m_steps = (m_steps < SMAX) ? m_steps + 1 : SMAX;
            if (m_out >= 9959) begin m_out = 0; m_done = 1; end
            else if (m_out % 100 == 59) m_out = (m_out / 100 + 1) * 100;
            else m_out = m_out + 1;
          end
          default: ;
        endcase
        if (stepped) begin
          m_steps = (m_steps < SMAX) ? m_steps + 1 : SMAX;
          if (LIM_EN && m_steps == LIM) begin m_st = 2; m_done = 1; end
        end
      end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Load = 0; En = 0; Mode = 0; Load_val = '0;
    #12;
    checks++;
    if (Out !== '0 || Valid !== 1'b0 || Done !== 1'b0 || Ovf !== 1'b0 || Steps !== '0) begin
      errors++;
      $display("FAIL reset_state out=%0d v=%b d=%b o=%b s=%0d, expected all zero", Out, Valid, Done, Ovf, Steps);
    end
    Rst_n = 1'b1;
    drive(0, 2'b00, '0, 1);
    checks++;
    if (Out !== '0 || Valid !== 1'b0 || Steps !== '0) begin
      errors++;
      $display("FAIL idle_ignores_en out=%0d v=%b s=%0d, expected 0/0/0", Out, Valid, Steps);
    end
  endtask

  task automatic test_fib();
    int exp_f[10] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
    drive(1, 2'b00, '0, 0);
    checks++;
    if (Out !== 16'd1 || Valid !== 1'b1 || Steps !== '0) begin
      errors++;
      $display("FAIL fib_load out=%0d v=%b s=%0d, expected 1/1/0", Out, Valid, Steps);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 2'b00, '0, 1);
      checks++;
      if (Out !== W'(exp_f[i])) begin
        errors++;
        $display("FAIL fib_seq[%0d] out=%0d, expected %0d", i, Out, exp_f[i]);
      end
    end
    checks++;
    if (Steps !== 8'd10 || Done !== 1'b0) begin
      errors++;
      $display("FAIL fib_steps steps=%0d done=%b, expected 10/0", Steps, Done);
    end
  endtask

  task automatic test_fib_ovf();
    drive(1, 2'b00, '0, 0);
    repeat (23) drive(0, 2'b00, '0, 1);
    checks++;
    if (Out !== 16'd46368 || Ovf !== 1'b0) begin
      errors++;
      $display("FAIL fib_23 out=%0d ovf=%b, expected 46368/0", Out, Ovf);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b00, '0, 1);
      checks++;
      if (Out !== 16'd46368 || Ovf !== 1'b1 || Done !== 1'b1 || Steps !== 8'd23) begin
        errors++;
        $display("FAIL fib_ovf[%0d] out=%0d ovf=%b done=%b steps=%0d, expected 46368/1/1/23", i, Out, Ovf, Done, Steps);
      end
    end
  endtask

  task automatic test_collatz();
    int peak, n;
    drive(1, 2'b01, '0, 0);
    checks++;
    if (Out !== 16'd27 || Valid !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL col_load out=%0d v=%b d=%b, expected 27/1/0", Out, Valid, Done);
    end
    peak = 27; n = 0;
    while (Done !== 1'b1 && n < 400) begin
      drive(0, 2'b01, '0, 1);
      n++;
      if (int'(Out) > peak) peak = int'(Out);
    end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL col_timeout done=%b after %0d steps, expected 1", Done, n);
    end
    checks++;
    if (Out !== 16'd1 || Steps !== 8'd111 || peak != 9232 || Ovf !== 1'b0) begin
      errors++;
      $display("FAIL col_term out=%0d steps=%0d peak=%0d ovf=%b, expected 1/111/9232/0", Out, Steps, peak, Ovf);
    end
  endtask

  task automatic test_stopwatch();
    drive(1, 2'b10, 16'd58, 0);
    drive(0, 2'b10, '0, 1);
    checks++;
    if (Out !== 16'd59) begin errors++; $display("FAIL sw_59 out=%0d, expected 59", Out); end
    drive(0, 2'b10, '0, 1);
    checks++;
    if (Out !== 16'd100) begin errors++; $display("FAIL sw_roll out=%0d, expected 100", Out); end
    drive(1, 2'b10, 16'd9959, 0);
    drive(0, 2'b10, '0, 1);
    checks++;
    if (Out !== '0 || Done !== 1'b1) begin
      errors++; $display("FAIL sw_wrap out=%0d done=%b, expected 0/1", Out, Done);
    end
    drive(0, 2'b10, '0, 0);
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL sw_pulse done=%b, expected 0", Done); end
    drive(1, 2'b10, 16'd75, 0);
    checks++;
    if (Out !== '0 || Valid !== 1'b1) begin
      errors++; $display("FAIL sw_bad_ss out=%0d v=%b, expected 0/1", Out, Valid);
    end
    drive(1, 2'b10, 16'd10030, 0);
    checks++;
    if (Out !== '0) begin errors++; $display("FAIL sw_over_max out=%0d, expected 0", Out); end
    // Mode input change without Load must not switch sequences.
    drive(0, 2'b00, '0, 1);
    checks++;
    if (Out !== 16'd1 || Steps !== 8'd1) begin
      errors++; $display("FAIL sw_mode_ignored out=%0d steps=%0d, expected 1/1", Out, Steps);
    end
  endtask

  task automatic test_load_priority();
    drive(1, 2'b00, '0, 0);
    repeat (3) drive(0, 2'b00, '0, 1);
    drive(1, 2'b00, '0, 1);
    checks++;
    if (Out !== 16'd1 || Steps !== '0 || Done !== 1'b0) begin
      errors++; $display("FAIL load_prio out=%0d steps=%0d done=%b, expected 1/0/0", Out, Steps, Done);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 2'b10, 16'd100, 0);
    repeat (3) drive(0, 2'b10, '0, 1);
    @(negedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (Out !== '0 || Valid !== 1'b0 || Steps !== '0 || Done !== 1'b0 || Ovf !== 1'b0) begin
      errors++; $display("FAIL async_rst out=%0d v=%b s=%0d, expected 0/0/0", Out, Valid, Steps);
    end
    #1 Rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    drive(1, 2'b10, '0, 0);
    repeat (260) drive(0, 2'b10, '0, 1);
    checks++;
    if (Steps !== 8'd255 || Out !== 16'd420) begin
      errors++; $display("FAIL steps_sat steps=%0d out=%0d, expected 255/420", Steps, Out);
    end
  endtask

`ifdef SEQ_STEP_LIMIT_EN
  task automatic test_step_limit();
    drive(1, 2'b00, '0, 0);
    repeat (7) drive(0, 2'b00, '0, 1);
    checks++;
    if (Out !== 16'd8 || Steps !== 8'd5 || Done !== 1'b1 || Ovf !== 1'b0) begin
      errors++; $display("FAIL step_limit out=%0d steps=%0d done=%b ovf=%b, expected 8/5/1/0", Out, Steps, Done, Ovf);
    end
  endtask
`endif

  task automatic test_random();
    logic         ld, en;
    logic [1:0]   md;
    logic [W-1:0] val;
    Rst_n = 1'b0; #2; Rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      ld  = ($urandom_range(0, 59) == 0);
      md  = 2'($urandom_range(0, 3));
      val = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 300));
      en  = 1'($urandom_range(0, 1));
      drive(ld, md, val, en);
      model_apply(ld, int'(md), int'(val), en);
      checks++;
      if (Out !== W'(m_out) || Valid !== m_valid || Done !== m_done || Ovf !== m_ovf || Steps !== SWD'(m_steps)) begin
        errors++;
        $display("FAIL rand[%0d] out=%0d v=%b d=%b o=%b s=%0d, expected %0d %b %b %b %0d",
                 i, Out, Valid, Done, Ovf, Steps, m_out, m_valid, m_done, m_ovf, m_steps);
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef SEQ_STEP_LIMIT_EN
    test_fib();
    test_fib_ovf();
    test_collatz();
`endif
    test_stopwatch();
    test_load_priority();
    test_async_reset();
    test_saturate();
`ifdef SEQ_STEP_LIMIT_EN
    test_step_limit();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
